// File: rtl/tp_fu_seq.sv
// Instruction sequencer for a functional unit: replays a loaded program
// prog_len words x iter times back-to-back, then drains FU_LATENCY cycles.
module tp_fu_seq #(
  parameter int INST_WIDTH     = 24,
  parameter int IMEM_ADDR_BITS = 6,
  parameter int FU_LATENCY     = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld_en,
  input  logic [IMEM_ADDR_BITS-1:0] ld_addr,
  input  logic [INST_WIDTH-1:0]     ld_data,
  input  logic                      start,
  input  logic [IMEM_ADDR_BITS:0]   prog_len,
  input  logic [7:0]                iter,
  input  logic                      abort,
  output logic [INST_WIDTH-1:0]     inst,
  output logic                      inst_valid,
  output logic [IMEM_ADDR_BITS-1:0] pc,
  output logic                      busy,
  output logic                      done
);

  localparam int LW    = IMEM_ADDR_BITS + 1;
  localparam int DEPTH = 1 << IMEM_ADDR_BITS;
  localparam int DW    = (FU_LATENCY > 1) ? $clog2(FU_LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_INIT = DW'(FU_LATENCY - 1);
  localparam logic [LW-1:0] MAX_LEN    = LW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                    r_state, w_state_nx;
  logic [INST_WIDTH-1:0]     r_inst, w_inst_nx;
  logic                      r_valid, w_valid_nx;
  logic [IMEM_ADDR_BITS-1:0] r_pc, w_pc_nx;
  logic [LW-1:0]             r_len, w_len_nx;
  logic [7:0]                r_iter, w_iter_nx;
  logic [DW-1:0]             r_drain, w_drain_nx;
  logic                      r_last, w_last_nx;

  logic [INST_WIDTH-1:0] r_imem [DEPTH];

  logic [LW-1:0] w_len_clamped;
  logic          w_pc_end;
  logic [7:0]    w_iter_dec;

  assign w_len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
  assign w_pc_end      = (LW'(r_pc) == (r_len - LW'(1)));
  // r_iter counts iterations remaining after the current one; it steps when
  // a fresh iteration begins (address 0 issued from RUN).
  assign w_iter_dec    = (r_pc == '0) ? (r_iter - 8'd1) : r_iter;

  always_ff @(posedge clk) begin
    if (ld_en && (r_state == S_IDLE)) begin
      r_imem[ld_addr] <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_len   <= '0;
      r_iter  <= '0;
      r_drain <= '0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_inst  <= w_inst_nx;
      r_valid <= w_valid_nx;
      r_pc    <= w_pc_nx;
      r_len   <= w_len_nx;
      r_iter  <= w_iter_nx;
      r_drain <= w_drain_nx;
      r_last  <= w_last_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_inst_nx  = '0;
    w_valid_nx = 1'b0;
    w_pc_nx    = r_pc;
    w_len_nx   = r_len;
    w_iter_nx  = r_iter;
    w_drain_nx = r_drain;
    w_last_nx  = r_last;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((w_len_clamped == '0) || (iter == 8'd0)) begin
            w_state_nx = S_DONE;
          end else begin
            w_inst_nx  = r_imem[0];
            w_valid_nx = 1'b1;
            w_pc_nx    = (w_len_clamped == LW'(1)) ? '0 : IMEM_ADDR_BITS'(1);
            w_len_nx   = w_len_clamped;
            w_iter_nx  = iter - 8'd1;
            w_last_nx  = (w_len_clamped == LW'(1)) && (iter == 8'd1);
            w_state_nx = S_RUN;
          end
        end
      end
      S_RUN: begin
        // r_last marks that the word now on inst is the final one.
        if (abort || r_last) begin
          w_drain_nx = DRAIN_INIT;
          w_last_nx  = 1'b0;
          w_state_nx = S_DRAIN;
        end else begin
          w_inst_nx  = r_imem[r_pc];
          w_valid_nx = 1'b1;
          w_iter_nx  = w_iter_dec;
          w_pc_nx    = w_pc_end ? '0 : (r_pc + IMEM_ADDR_BITS'(1));
          w_last_nx  = w_pc_end && (w_iter_dec == 8'd0);
        end
      end
      S_DRAIN: begin
        if (r_drain == '0) begin
          w_state_nx = S_DONE;
        end else begin
          w_drain_nx = r_drain - DW'(1);
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  assign inst       = r_inst;
  assign inst_valid = r_valid;
  assign pc         = r_pc;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_tp_fu_seq.sv
// Scoreboard bench for tp_fu_seq: stimulus pushes expected words and done gaps,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_tp_fu_seq;

  localparam int IW  = 24;
  localparam int AB  = 6;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_en;
  logic [AB-1:0] ld_addr;
  logic [IW-1:0] ld_data;
  logic          start;
  logic [AB:0]   prog_len;
  logic [7:0]    iter;
  logic          abort;
  logic [IW-1:0] inst;
  logic          inst_valid;
  logic [AB-1:0] pc;
  logic          busy;
  logic          done;

  tp_fu_seq #(.INST_WIDTH(IW), .IMEM_ADDR_BITS(AB), .FU_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .start(start), .prog_len(prog_len), .iter(iter), .abort(abort),
    .inst(inst), .inst_valid(inst_valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [AB-1:0] pc;
  } exp_t;

  exp_t          exp_q[$];
  int            done_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] model [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Monitor
  initial begin
    int   gap;
    exp_t e;
    gap = 0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        gap = 0;
      end else if (inst_valid) begin
        check("done_during_valid", {31'd0, done}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word: got inst %0h pc %0h expected none", inst, pc);
        end else begin
          e = exp_q.pop_front();
          check("inst", inst, e.inst);
          check("pc", pc, e.pc);
        end
        gap = 0;
      end else begin
        check("inst_zero_when_invalid", inst, 32'd0);
        if (!busy) begin
          gap = 0;
        end else if (done) begin
          if (done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 expected 0");
          end else begin
            check("done_gap", gap, done_q.pop_front());
          end
        end else begin
          gap++;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [IW-1:0] d);
    ld_en = 1'b1; ld_addr = a[AB-1:0]; ld_data = d;
    model[a] = d;
    tick;
    ld_en = 1'b0;
  endtask

  task automatic push_prog(input int len, input int it, input int nwords);
    exp_t e;
    int   eff, a;
    eff = (len > 64) ? 64 : len;
    for (int i = 0; i < nwords; i++) begin
      a = i % eff;
      e.inst = model[a];
      e.pc   = (a == eff - 1) ? AB'(0) : AB'(a + 1);
      exp_q.push_back(e);
    end
    done_q.push_back((eff == 0 || it == 0) ? 0 : LAT);
  endtask

  task automatic wait_idle(input string name, input int expc);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick;
      n++;
    end
    check(name, n, expc);
  endtask

  task automatic run(input int len, input int it, input logic ab, input string name);
    int eff;
    eff = (len > 64) ? 64 : len;
    push_prog(len, it, eff * it);
    prog_len = len[AB:0]; iter = it[7:0]; start = 1'b1; abort = ab;
    tick;
    start = 1'b0; abort = 1'b0;
    wait_idle(name, (eff * it == 0) ? 1 : eff * it + LAT + 1);
  endtask

  initial begin
    rst = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    start = 1'b0; prog_len = '0; iter = '0; abort = 1'b0;
    tick; tick;
    rst = 1'b0;
    check("rst_inst", inst, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);

    load(0, 24'h058041);
    load(1, 24'h0C8082);
    load(2, 24'h8C3001);
    for (int i = 3; i < 64; i++) load(i, IW'((i * 37 + 5) ^ 24'h5A0000));

    run(3, 1, 1'b0, "busy_len3_it1");
    run(2, 3, 1'b0, "busy_len2_it3");
    run(64, 2, 1'b0, "busy_len64_it2");

    // Abort on first RUN edge; a load during RUN must be dropped.
    push_prog(5, 1, 1);
    prog_len = 7'd5; iter = 8'd1; start = 1'b1;
    tick;
    start = 1'b0; abort = 1'b1;
    ld_en = 1'b1; ld_addr = '0; ld_data = 24'hDEAD00;
    tick;
    abort = 1'b0; ld_en = 1'b0;
    wait_idle("busy_abort", LAT + 1);

    run(3, 1, 1'b0, "busy_after_dropped_ld");
    run(100, 1, 1'b0, "busy_len_clamp");
    run(2, 1, 1'b1, "busy_start_beats_abort");

    // Reset mid-RUN: no more words, no done pulse.
    push_prog(4, 2, 8);
    prog_len = 7'd4; iter = 8'd2; start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    check("midrun_rst_inst", inst, 32'd0);
    check("midrun_rst_valid", {31'd0, inst_valid}, 32'd0);
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_pc", pc, 32'd0);
    for (int i = 0; i < 6; i++) tick;

    run(3, 0, 1'b0, "busy_iter0");
    run(0, 4, 1'b0, "busy_len0");
    run(2, 1, 1'b0, "busy_imem_kept_after_rst");
    run(1, 3, 1'b0, "busy_len1_it3");

    tick; tick;
    check("words_left", exp_q.size(), 32'd0);
    check("dones_left", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
